// File: rtl/div_seq.sv
// Iterative restoring divider, one quotient bit per clock, result {remainder, quotient}.
// Latency: start sampled at edge 0, done pulses in the cycle after edge WIDTH+2.
// Backpressure: none; start is taken only in IDLE and ignored while a division runs.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // shifts in dividend MSB-first, fills with quotient bits
  logic [WIDTH-1:0] dvsr_q;     // |divisor|
  logic [WIDTH-1:0] dvnd_q;     // original dividend, returned as remainder on divide-by-zero
  logic             qneg_q;     // quotient must be negated
  logic             rneg_q;     // remainder takes the dividend's negative sign
  logic             dz_q;       // divisor was zero
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             dvnd_neg;
  logic             dvsr_neg;

  assign dvnd_neg = is_signed & dividend[WIDTH-1];
  assign dvsr_neg = is_signed & divisor[WIDTH-1];

  // One restoring step: shift next dividend bit into the remainder and trial-subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign/zero fix-up, result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      dvnd_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          rem_q  <= '0;
          quo_q  <= dvnd_neg ? (~dividend + 1'b1) : dividend;
          dvsr_q <= dvsr_neg ? (~divisor + 1'b1) : divisor;
          dvnd_q <= dividend;
          qneg_q <= dvnd_neg ^ dvsr_neg;
          rneg_q <= dvnd_neg;
          dz_q   <= (divisor == '0);
          cnt_q  <= CW'(WIDTH - 1);
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          // Divide-by-zero wins over sign correction.
          if (dz_q) begin
            quo_q <= '1;
            rem_q <= dvnd_q;
          end else begin
            if (qneg_q) quo_q <= ~quo_q + 1'b1;
            if (rneg_q) rem_q <= ~rem_q + 1'b1;
          end
        end
        DONE: begin
          result   <= {rem_q, quo_q};
          div_zero <= dz_q;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: driver pushes expected responses, monitor checks on done.
// Latency: expects done exactly 34 edges after the start edge.
// Backpressure: none; the driver waits for done before issuing the next start.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_zero;

  div_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          st;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to measure start-to-done latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc - e.st), 64'd34);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  // Waits (bounded) at negedges for done; returns number of busy cycles seen before it.
  task automatic wait_done(output int nb);
    bit seen;
    seen = 1'b0;
    nb   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) nb++;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  // Issue one start at the current negedge, scramble inputs after the edge, push expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input bit push);
    exp_t e;
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = sg;
    @(posedge clk);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~sg;
    if (push) begin
      e.res = {er, eq};
      e.dz  = edz;
      e.st  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sg,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int nb;
    issue(a, b, sg, eq, er, edz, 1'b1);
    wait_done(nb);
    chk("busy_cycles", 64'(nb), 64'd33);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors; each run starts in the cycle done of the previous one is high.
    run(32'd12,         32'd9,          1'b0, 32'd1,          32'd3,          1'b0);
    run(32'hfffffffe,   32'd9,          1'b0, 32'h1c71c71c,   32'd2,          1'b0);
    run(32'hfffffffe,   32'd9,          1'b1, 32'd0,          32'hfffffffe,   1'b0);
    run(32'hfffffff9,   32'd2,          1'b1, 32'hfffffffd,   32'hffffffff,   1'b0);
    run(32'd7,          32'hfffffffe,   1'b1, 32'hfffffffd,   32'd1,          1'b0);
    run(32'd100,        32'd0,          1'b0, 32'hffffffff,   32'd100,        1'b1);
    run(32'hfffffffe,   32'd0,          1'b1, 32'hffffffff,   32'hfffffffe,   1'b1);
    run(32'h80000000,   32'hffffffff,   1'b1, 32'h80000000,   32'd0,          1'b0);
    run(32'h80000000,   32'hffffffff,   1'b0, 32'd0,          32'h80000000,   1'b0);
    run(32'hffffff9c,   32'hfffffff9,   1'b1, 32'd14,         32'hfffffffe,   1'b0);

    // Held outputs after done: div_zero from the last op stays 0, result stays put.
    repeat (5) @(negedge clk);
    chk("hold_result", result, {32'hfffffffe, 32'd14});
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Second start mid-CALC with new operands must be ignored.
    issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    issue(32'd5, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_done(nb);
    repeat (40) @(negedge clk);
    chk("no_second_result", 64'(sb.size()), 64'd0);
    chk("idle_after_ignored", {63'd0, busy}, 64'd0);

    // Reset mid-operation aborts without a done pulse.
    issue(32'd1000, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", {63'd0, busy}, 64'd0);
    chk("abort_result_held", result, 64'd0);

    // Fresh division after reset.
    run(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0);
    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
